// File: rtl/usb_ps2_keyfifo_pkg.sv
// Shared types and constants for the USB->PS/2 scancode FIFO.
// Holds the overrun marker default, the counter-width helper and the state/select enums.
package usb_ps2_keyfifo_pkg;

    localparam logic [7:0] OVF_DEFAULT = 8'hFF;

    // Counter must hold DEPTH itself, hence depth+1.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef enum logic {
        ARM_WAIT = 1'b0,
        ARM_LIVE = 1'b1
    } arm_state_t;

    typedef enum logic [1:0] {
        SRC_EMPTY = 2'd0,
        SRC_HEAD  = 2'd1,
        SRC_MARK  = 2'd2
    } out_src_t;

endpackage

// File: rtl/usb_ps2_keyfifo_if.sv
// Bundle of the scancode write side and the CPU key-read side of the FIFO.
// The master drives scancodes, updates and read/flush strobes; the slave is the FIFO.
interface usb_ps2_keyfifo_if
    import usb_ps2_keyfifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [DATA_W-1:0] kb_scancode;
    logic              kb_scancode_upd;
    logic              keybuf_rd;
    logic              keybuf_reset;
    logic [DATA_W-1:0] keybuf_data;
    logic              keybuf_valid;
    logic [CNT_W-1:0]  keybuf_count;
    logic              keybuf_full;
    logic              keybuf_ovf;

    modport master (
        output kb_scancode, kb_scancode_upd, keybuf_rd, keybuf_reset,
        input  keybuf_data, keybuf_valid, keybuf_count, keybuf_full, keybuf_ovf
    );

    modport slave (
        input  kb_scancode, kb_scancode_upd, keybuf_rd, keybuf_reset,
        output keybuf_data, keybuf_valid, keybuf_count, keybuf_full, keybuf_ovf
    );

endinterface

// File: rtl/usb_ps2_keyfifo_fwft.sv
// Show-ahead storage FIFO: array storage, wrapping pointers, occupancy count.
// The head is a registered read of the next read address, bypassed when that slot is written.
module kbd_fifo_fwft
    import usb_ps2_keyfifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    localparam int CNT_W = cnt_width(DEPTH),
    localparam int PTR_W = ptr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] head_reg;
    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]  count_reg, count_next;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(wr_en);
            rd_ptr_next = rd_ptr_reg + PTR_W'(rd_en);
            count_next  = count_reg + CNT_W'(wr_en) - CNT_W'(rd_en);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Head tracks mem[rd_ptr]; a same-edge write into that slot must win over the stale word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= wr_data;
        end
        head_reg <= (wr_en && (wr_ptr_reg == rd_ptr_next)) ? wr_data : mem[rd_ptr_next];
    end

    assign rd_data = head_reg;
    assign count   = count_reg;
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);

endmodule

// File: rtl/usb_ps2_keyfifo.sv
// Scancode FIFO front end: arming after reset, write toggle/pulse detect, read edge detect,
// sticky overrun flag whose marker is presented after all buffered bytes.
module usb_ps2_keyfifo
    import usb_ps2_keyfifo_pkg::*;
#(
    parameter int              DATA_W    = 8,
    parameter int              DEPTH     = 16,
    parameter logic [DATA_W-1:0] OVF_CODE = DATA_W'(OVF_DEFAULT),
    parameter bit              TOGGLE_WR = 1'b1,
    parameter bit              RD_EDGE   = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    usb_ps2_keyfifo_if.slave   bus
);

    localparam int CNT_W = cnt_width(DEPTH);

    arm_state_t        arm_reg, arm_next;
    logic              armed;
    logic              prev_upd_reg;
    logic              wr_stb_reg, wr_stb_next;
    logic [DATA_W-1:0] wr_data_reg;
    logic              rd_q_reg;
    logic              ovf_reg, ovf_next;

    logic              rd_stb;
    logic              pop_real, pop_mark;
    logic              wr_accept, wr_drop;
    logic              fifo_wr_en, fifo_rd_en;
    logic [DATA_W-1:0] fifo_head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full, fifo_empty;
    out_src_t          out_src;

    // Arming swallows the first cycle so an upd level held through reset is not seen as a write.
    always_comb begin
        arm_next = arm_reg;
        armed    = 1'b0;
        case (arm_reg)
            ARM_WAIT: arm_next = ARM_LIVE;
            ARM_LIVE: armed    = 1'b1;
            default:  arm_next = ARM_WAIT;
        endcase
    end

    assign wr_stb_next = armed && (TOGGLE_WR ? (bus.kb_scancode_upd != prev_upd_reg)
                                             : bus.kb_scancode_upd);
    assign rd_stb      = RD_EDGE ? (bus.keybuf_rd && !rd_q_reg) : bus.keybuf_rd;

    assign pop_real  = rd_stb && !fifo_empty;
    assign pop_mark  = rd_stb && fifo_empty && ovf_reg;
    assign wr_accept = wr_stb_reg && (!fifo_full || pop_real);
    assign wr_drop   = wr_stb_reg && fifo_full && !pop_real;

    assign fifo_wr_en = wr_accept && !bus.keybuf_reset;
    assign fifo_rd_en = pop_real && !bus.keybuf_reset;

    always_comb begin
        ovf_next = ovf_reg;
        if (bus.keybuf_reset) begin
            ovf_next = 1'b0;
        end else if (wr_drop) begin
            ovf_next = 1'b1;
        end else if (pop_mark) begin
            ovf_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_reg      <= ARM_WAIT;
            prev_upd_reg <= 1'b0;
            wr_stb_reg   <= 1'b0;
            wr_data_reg  <= '0;
            rd_q_reg     <= 1'b0;
            ovf_reg      <= 1'b0;
        end else begin
            arm_reg      <= arm_next;
            prev_upd_reg <= bus.kb_scancode_upd;
            wr_stb_reg   <= wr_stb_next;
            wr_data_reg  <= bus.kb_scancode;
            rd_q_reg     <= bus.keybuf_rd;
            ovf_reg      <= ovf_next;
        end
    end

    kbd_fifo_fwft #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (bus.keybuf_reset),
        .wr_en   (fifo_wr_en),
        .wr_data (wr_data_reg),
        .rd_en   (fifo_rd_en),
        .rd_data (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Stored bytes always drain before the overrun marker is shown.
    always_comb begin
        out_src = SRC_EMPTY;
        if (!fifo_empty) begin
            out_src = SRC_HEAD;
        end else if (ovf_reg) begin
            out_src = SRC_MARK;
        end
    end

    always_comb begin
        bus.keybuf_data  = '0;
        bus.keybuf_valid = 1'b0;
        case (out_src)
            SRC_HEAD: begin
                bus.keybuf_data  = fifo_head;
                bus.keybuf_valid = 1'b1;
            end
            SRC_MARK: begin
                bus.keybuf_data  = OVF_CODE;
                bus.keybuf_valid = 1'b1;
            end
            default: begin
                bus.keybuf_data  = '0;
                bus.keybuf_valid = 1'b0;
            end
        endcase
    end

    assign bus.keybuf_count = fifo_count;
    assign bus.keybuf_full  = fifo_full;
    assign bus.keybuf_ovf   = ovf_reg;

endmodule
